prg_mem_arbiter: RTL and testbench

//  Shares one single-port program memory (1-cycle registered read, read-first on write) between two requesters.

---
 rtl/prg_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_prg_mem_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/prg_mem_arbiter.sv
// Two-port arbiter sharing one single-port program memory between CPU fetch (A) and loader/debug (B).
// Optional build macro PRG_ARB_ROUND_ROBIN_EN selects round-robin arbitration in SERVE instead of fixed B>A priority.
module prg_mem_arbiter #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 9,
  parameter int MAX_WAIT      = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     a_req_valid,
  output logic                     a_req_ready,
  input  logic [RAM_ADDR_BITS-1:0] a_addr,
  output logic                     a_rsp_valid,
  output logic [RAM_WIDTH-1:0]     a_rsp_data,
  input  logic                     b_req_valid,
  output logic                     b_req_ready,
  input  logic                     b_we,
  input  logic [RAM_ADDR_BITS-1:0] b_addr,
  input  logic [RAM_WIDTH-1:0]     b_wdata,
  input  logic                     b_lock,
  output logic                     b_locked,
  output logic                     b_rsp_valid,
  output logic [RAM_WIDTH-1:0]     b_rsp_data,
  output logic                     mem_enable,
  output logic                     mem_write_enable,
  output logic [RAM_ADDR_BITS-1:0] mem_address,
  output logic [RAM_WIDTH-1:0]     mem_in_data,
  input  logic [RAM_WIDTH-1:0]     mem_out_data
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {SERVE, LOCKED, DRAIN} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

  state_t         state_q, state_d;
  owner_t         rsp_owner_q, rsp_owner_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           grant_a, grant_b;
  logic           force_a;
  logic           a_pref;

`ifdef PRG_ARB_ROUND_ROBIN_EN
  // rr_q == 0 means A holds priority for the next contended cycle
  logic rr_q, rr_d;
`endif

  always_comb begin
    state_d     = state_q;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    force_a     = (wait_cnt_q == WCW'(MAX_WAIT));
`ifdef PRG_ARB_ROUND_ROBIN_EN
    rr_d        = rr_q;
    a_pref      = force_a | ~rr_q;
`else
    a_pref      = force_a;
`endif

    case (state_q)
      SERVE: begin
        if (a_req_valid && (a_pref || !b_req_valid)) begin
          grant_a = 1'b1;
        end else if (b_req_valid) begin
          grant_b = 1'b1;
        end
        if (grant_b && b_lock) begin
          state_d = LOCKED;
        end
`ifdef PRG_ARB_ROUND_ROBIN_EN
        if (a_req_valid && b_req_valid) begin
          rr_d = grant_a;
        end
`endif
      end
      LOCKED: begin
        grant_b = b_req_valid;
        if (!b_lock) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = SERVE;
      end
      default: begin
        state_d = SERVE;
      end
    endcase

    // Keep the memory quiet while reset is held
    if (reset) begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end

    if (state_q == LOCKED) begin
      wait_cnt_d = wait_cnt_q;
    end else if (!a_req_valid || grant_a) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WCW'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    if (grant_a) begin
      rsp_owner_d = OWN_A;
    end else if (grant_b) begin
      rsp_owner_d = OWN_B;
    end else begin
      rsp_owner_d = OWN_NONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= SERVE;
      rsp_owner_q <= OWN_NONE;
      wait_cnt_q  <= '0;
`ifdef PRG_ARB_ROUND_ROBIN_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rsp_owner_q <= rsp_owner_d;
      wait_cnt_q  <= wait_cnt_d;
`ifdef PRG_ARB_ROUND_ROBIN_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign a_req_ready      = grant_a;
  assign b_req_ready      = grant_b;
  assign b_locked         = (state_q == LOCKED);
  assign mem_enable       = grant_a | grant_b;
  assign mem_write_enable = grant_b & b_we;
  assign mem_address      = grant_a ? a_addr : (grant_b ? b_addr : '0);
  assign mem_in_data      = (grant_b & b_we) ? b_wdata : '0;

  // Read data is steered to whichever port was granted on the previous edge
  assign a_rsp_valid = (rsp_owner_q == OWN_A);
  assign b_rsp_valid = (rsp_owner_q == OWN_B);
  assign a_rsp_data  = a_rsp_valid ? mem_out_data : '0;
  assign b_rsp_data  = b_rsp_valid ? mem_out_data : '0;

endmodule

// File: tb/tb_prg_mem_arbiter.sv
// Scoreboard bench for prg_mem_arbiter: directed grant checks plus a response monitor against a memory model.
module tb_prg_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        a_req_valid, a_req_ready, a_rsp_valid;
  logic [8:0]  a_addr;
  logic [31:0] a_rsp_data;
  logic        b_req_valid, b_req_ready, b_we, b_lock, b_locked, b_rsp_valid;
  logic [8:0]  b_addr;
  logic [31:0] b_wdata, b_rsp_data;
  logic        mem_enable, mem_write_enable;
  logic [8:0]  mem_address;
  logic [31:0] mem_in_data, mem_out_data;

  prg_mem_arbiter #(.RAM_WIDTH(32), .RAM_ADDR_BITS(9), .MAX_WAIT(7)) dut (
    .clock(clock), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_addr(a_addr),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_we(b_we),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock), .b_locked(b_locked),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_in_data(mem_in_data), .mem_out_data(mem_out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port RAM with registered read, read-first on write
  logic [31:0] mem     [512];
  logic [31:0] ref_mem [512];
  always @(posedge clock) begin
    if (mem_enable) begin
      mem_out_data <= mem[mem_address];
      if (mem_write_enable) mem[mem_address] <= mem_in_data;
    end
  end

  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   ea_m, eb_m;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: every grant must produce exactly one response on the following cycle
  always @(negedge clock) begin
    if (!reset) begin
      ea_m = (qa.size() > 0) && (qa[0].due == cyc);
      eb_m = (qb.size() > 0) && (qb[0].due == cyc);
      if (ea_m || a_rsp_valid) begin
        chk("a_rsp_valid", {31'd0, a_rsp_valid}, {31'd0, ea_m});
        if (ea_m && a_rsp_valid) begin
          chk("a_rsp_data", a_rsp_data, qa[0].data);
          $display("a_rsp data=%h", a_rsp_data);
        end
        if (ea_m) void'(qa.pop_front());
      end
      if (eb_m || b_rsp_valid) begin
        chk("b_rsp_valid", {31'd0, b_rsp_valid}, {31'd0, eb_m});
        if (eb_m && b_rsp_valid) begin
          chk("b_rsp_data", b_rsp_data, qb[0].data);
          $display("b_rsp data=%h", b_rsp_data);
        end
        if (eb_m) void'(qb.pop_front());
      end
    end
  end

  // One bus cycle: drive, check grants/lock at negedge, push expected responses
  task automatic step(input logic av, input logic [8:0] aa,
                      input logic bv, input logic bw, input logic [8:0] ba,
                      input logic [31:0] bd, input logic bl,
                      input logic ega, input logic egb, input logic elk, input string tag);
    a_req_valid = av; a_addr = aa;
    b_req_valid = bv; b_we = bw; b_addr = ba; b_wdata = bd; b_lock = bl;
    @(negedge clock);
    chk({tag, " a_req_ready"}, {31'd0, a_req_ready}, {31'd0, ega});
    chk({tag, " b_req_ready"}, {31'd0, b_req_ready}, {31'd0, egb});
    chk({tag, " b_locked"},    {31'd0, b_locked},    {31'd0, elk});
    if (a_req_ready) qa.push_back('{ref_mem[a_addr], cyc + 1});
    if (b_req_ready) begin
      qb.push_back('{ref_mem[b_addr], cyc + 1});
      if (b_we) ref_mem[b_addr] = bd;
    end
    @(posedge clock); #1;
  endtask

  task automatic idle(input logic eb_lk, input string tag);
    step(1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 1'b0, eb_lk, tag);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]     = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    reset = 1'b1;
    a_req_valid = 1'b1; a_addr = 9'd5;
    b_req_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_lock = 1'b0;

    // 1: reset with A pending
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst a_req_ready", {31'd0, a_req_ready}, 32'd0);
    chk("rst a_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rst b_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
    chk("rst b_locked",    {31'd0, b_locked},    32'd0);
    chk("rst mem_enable",  {31'd0, mem_enable},  32'd0);
    @(posedge clock); #1;
    reset = 1'b0; a_req_valid = 1'b0;
    idle(1'b0, "t1 idle0");
    chk("t1 no a_rsp", {31'd0, a_rsp_valid}, 32'd0);
    idle(1'b0, "t1 idle1");
    step(1'b1, 9'd5, 1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, "t1 a5");
    chk("t1 a_rsp_data", a_rsp_data, 32'h1000_0005);

    // 2: B write then A read of same address
    step(1'b0, 9'd0, 1'b1, 1'b1, 9'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, "t2 bw3");
    chk("t2 b_old_data", b_rsp_data, 32'h1000_0003);
    step(1'b1, 9'd3, 1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, "t2 ar3");
    chk("t2 a_new_data", a_rsp_data, 32'hDEAD_BEEF);
    idle(1'b0, "t2 idle");

    // 3/4: both requesters saturating
    for (int k = 0; k < 16; k++) begin
`ifdef PRG_ARB_ROUND_ROBIN_EN
      step(1'b1, 9'd20, 1'b1, 1'b0, 9'(40 + k), 32'd0, 1'b0,
           (k % 2 == 0), (k % 2 == 1), 1'b0, $sformatf("t4 k%0d", k));
`else
      step(1'b1, 9'd20, 1'b1, 1'b0, 9'(40 + k), 32'd0, 1'b0,
           (k == 7 || k == 15), !(k == 7 || k == 15), 1'b0, $sformatf("t3 k%0d", k));
`endif
    end

`ifndef PRG_ARB_ROUND_ROBIN_EN
    // Lock request collides with the forced A grant: A wins, lock taken on next B grant
    for (int k = 0; k < 7; k++)
      step(1'b1, 9'd21, 1'b1, 1'b0, 9'(60 + k), 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, $sformatf("tg k%0d", k));
    step(1'b1, 9'd21, 1'b1, 1'b0, 9'd70, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, "tg force");
    step(1'b1, 9'd21, 1'b1, 1'b0, 9'd70, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, "tg lockgrant");
    step(1'b1, 9'd21, 1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, "tg unlock");
    step(1'b1, 9'd21, 1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, "tg drain");
`endif

    // 5: locked burst of four writes while A waits
    step(1'b0, 9'd0, 1'b1, 1'b1, 9'd100, 32'hA000_0000, 1'b1, 1'b0, 1'b1, 1'b0, "t5 w0");
    for (int k = 1; k < 4; k++)
      step(1'b1, 9'd101, 1'b1, 1'b1, 9'(100 + k), 32'hA000_0000 + k, 1'b1,
           1'b0, 1'b1, 1'b1, $sformatf("t5 w%0d", k));
    step(1'b1, 9'd101, 1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, "t5 unlock");
    step(1'b1, 9'd101, 1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, "t5 drain");
    step(1'b1, 9'd101, 1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, "t5 a_after");
    chk("t5 a_read_locked_write", a_rsp_data, 32'hA000_0001);
    idle(1'b0, "t5 idle");

    // 6: reset while locked with a B read in flight
    step(1'b0, 9'd0, 1'b1, 1'b0, 9'd6, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, "t6 b6");
    step(1'b0, 9'd0, 1'b1, 1'b0, 9'd7, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, "t6 b7");
    chk("t6 b_rsp_inflight", {31'd0, b_rsp_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6 rst b_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
    chk("t6 rst b_locked",    {31'd0, b_locked},    32'd0);
    qa.delete(); qb.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    b_req_valid = 1'b0; b_lock = 1'b0;
    idle(1'b0, "t6 idle");
    step(1'b1, 9'd8, 1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, "t6 serve");
    idle(1'b0, "t6 tail0");
    idle(1'b0, "t6 tail1");
    chk("end qa empty", qa.size(), 32'd0);
    chk("end qb empty", qb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
